// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: on an accepted start it emits a burst of
// packets whose beats carry seed + packet_index + beat_index.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           burst request, sampled only while idle
//   pkt_len         beats per packet (latched on accepted start)
//   num_pkts        packets per burst (latched on accepted start)
//   gap             idle cycles between packets (latched on accepted start)
//   seed            base data value (latched on accepted start)
//   m_tdata/m_tvalid/m_tlast/m_tready  AXI-Stream master side
//   busy            burst in progress
//   done            one-cycle pulse on burst completion
//   pkt_cnt         packets fully transferred in current/last burst
module axis_pkt_gen #(
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] pkt_len,
    input  logic [7:0]    num_pkts,
    input  logic [7:0]    gap,
    input  logic [DW-1:0] seed,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          busy,
    output logic          done,
    output logic [7:0]    pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t        state_q, state_d;

    // Latched burst configuration
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    npk_q, npk_d;
    logic [7:0]    gap_q, gap_d;
    logic [DW-1:0] seed_q, seed_d;

    // Position within the burst
    logic [LW-1:0] beat_q, beat_d;
    logic [7:0]    pidx_q, pidx_d;
    logic [7:0]    gcnt_q, gcnt_d;

    // Registered outputs
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          accept;
    logic          xfer;
    logic          last_pkt;

    assign accept   = start && (pkt_len != '0) && (num_pkts != 8'd0);
    assign xfer     = tvalid_q && m_tready;
    assign last_pkt = (pidx_q == npk_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            npk_q    <= '0;
            gap_q    <= '0;
            seed_q   <= '0;
            beat_q   <= '0;
            pidx_q   <= '0;
            gcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            npk_q    <= npk_d;
            gap_q    <= gap_d;
            seed_q   <= seed_d;
            beat_q   <= beat_d;
            pidx_q   <= pidx_d;
            gcnt_q   <= gcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        npk_d    = npk_q;
        gap_d    = gap_q;
        seed_d   = seed_q;
        beat_d   = beat_q;
        pidx_d   = pidx_q;
        gcnt_d   = gcnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                tdata_d  = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
                if (accept) begin
                    len_d    = pkt_len;
                    npk_d    = num_pkts;
                    gap_d    = gap;
                    seed_d   = seed;
                    beat_d   = '0;
                    pidx_d   = '0;
                    cnt_d    = '0;
                    state_d  = SEND;
                    busy_d   = 1'b1;
                    tvalid_d = 1'b1;
                    tdata_d  = seed;
                    tlast_d  = (pkt_len == LW'(1));
                end
            end

            SEND: begin
                if (xfer) begin
                    if (tlast_q) begin
                        cnt_d  = cnt_q + 8'd1;
                        beat_d = '0;
                        if (last_pkt) begin
                            state_d  = IDLE;
                            tdata_d  = '0;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            pidx_d = pidx_q + 8'd1;
                            if (gap_q != 8'd0) begin
                                state_d  = GAP;
                                gcnt_d   = gap_q;
                                tdata_d  = '0;
                                tvalid_d = 1'b0;
                                tlast_d  = 1'b0;
                            end else begin
                                // Back-to-back: next packet's first beat
                                tvalid_d = 1'b1;
                                tdata_d  = seed_q + DW'(pidx_q + 8'd1);
                                tlast_d  = (len_q == LW'(1));
                            end
                        end
                    end else begin
                        beat_d  = beat_q + LW'(1);
                        tdata_d = tdata_q + DW'(1);
                        // Next beat is final when beat_q + 1 == len - 1
                        tlast_d = ((beat_q + LW'(2)) == len_q);
                    end
                end
            end

            GAP: begin
                // gcnt_q counts the remaining low cycles, this one included
                if (gcnt_q == 8'd1) begin
                    state_d  = SEND;
                    gcnt_d   = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = seed_q + DW'(pidx_q);
                    tlast_d  = (len_q == LW'(1));
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end

            default: begin
                state_d  = IDLE;
                tdata_d  = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pkt_cnt  = cnt_q;

endmodule
